// File: rtl/mc14500_pkg.sv
// Shared definitions for the mc14500 program sequencer: instruction word
// layout, opcode values and field-slice helpers.
package mc14500_pkg;

  localparam int INST_W = 12;
  localparam int OPC_W  = 4;
  localparam int OPR_W  = 8;

  localparam logic [OPC_W-1:0] OP_NOPO = 4'h0;
  localparam logic [OPC_W-1:0] OP_LD   = 4'h1;
  localparam logic [OPC_W-1:0] OP_LDC  = 4'h2;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
  localparam logic [OPC_W-1:0] OP_ANDC = 4'h4;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h5;
  localparam logic [OPC_W-1:0] OP_ORC  = 4'h6;
  localparam logic [OPC_W-1:0] OP_XNOR = 4'h7;
  localparam logic [OPC_W-1:0] OP_STO  = 4'h8;
  localparam logic [OPC_W-1:0] OP_STOC = 4'h9;
  localparam logic [OPC_W-1:0] OP_IEN  = 4'hA;
  localparam logic [OPC_W-1:0] OP_OEN  = 4'hB;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'hC;
  localparam logic [OPC_W-1:0] OP_RTN  = 4'hD;
  localparam logic [OPC_W-1:0] OP_SKZ  = 4'hE;
  localparam logic [OPC_W-1:0] OP_NOPF = 4'hF;

  typedef struct packed {
    logic [OPR_W-1:0] operand;
    logic [OPC_W-1:0] opcode;
  } inst_t;

  function automatic logic [OPC_W-1:0] get_opcode(input logic [INST_W-1:0] word);
    inst_t inst;
    inst = inst_t'(word);
    return inst.opcode;
  endfunction

  function automatic logic [OPR_W-1:0] get_operand(input logic [INST_W-1:0] word);
    inst_t inst;
    inst = inst_t'(word);
    return inst.operand;
  endfunction

endpackage

// File: rtl/mc14500_retstack.sv
// Return-address LIFO. Pushes into a full stack and pops from an empty
// one are ignored; the caller decides what that means.
module mc14500_retstack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      sp_r;
  logic [AW-1:0]    top_idx_s;

  // sp counts entries; the MSB alone marks a full stack since DEPTH is a power of two
  assign top_idx_s = sp_r[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
  assign top       = mem_r[top_idx_s];
  assign full      = sp_r[AW];
  assign empty     = (sp_r == {(AW+1){1'b0}});

  // Stack pointer and storage update
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push && !full) begin
      mem_r[sp_r[AW-1:0]] <= push_data;
      sp_r                <= sp_r + {{AW{1'b0}}, 1'b1};
    end else if (pop && !empty) begin
      sp_r <= sp_r - {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/mc14500_seq.sv
// Program sequencer and I/O bit-mapper wrapped around the mc14500b ICU:
// PC, JMP/CALL/RTN handling, input steering and output bit latches.
module mc14500_seq
  import mc14500_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4,
  parameter int IN_W        = 8,
  parameter int OUT_W       = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              run,
  output logic [PC_W-1:0]   prog_addr,
  input  logic [INST_W-1:0] prog_data,
  output logic [OPC_W-1:0]  core_i,
  output logic              core_data,
  input  logic              core_jmp,
  input  logic              core_rtn,
  input  logic              core_flag_f,
  input  logic              core_write,
  input  logic              core_dout,
  input  logic [IN_W-1:0]   in_pins,
  output logic [OUT_W-1:0]  out_pins,
  output logic              stack_err
);

  localparam int IN_AW  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int OUT_AW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [OPR_W:0]  IN_LIM  = (OPR_W+1)'(IN_W);
  localparam logic [OPR_W:0]  OUT_LIM = (OPR_W+1)'(OUT_W);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1'b1);

  logic [PC_W-1:0]  pc_r;
  logic [PC_W-1:0]  pc_next_s;
  logic [PC_W-1:0]  pc_inc_s;
  logic [PC_W-1:0]  opr_pc_s;
  logic [OPR_W-1:0] operand_s;
  logic [IN_AW-1:0] in_idx_s;
  logic [OUT_AW-1:0] out_idx_s;
  logic             in_ok_s;
  logic             out_ok_s;
  logic             push_s;
  logic             pop_s;
  logic             err_set_s;
  logic [PC_W-1:0]  top_s;
  logic             full_s;
  logic             empty_s;
  logic [OUT_W-1:0] out_r;
  logic             err_r;

  assign operand_s = get_operand(prog_data);
  assign core_i    = get_opcode(prog_data);
  assign opr_pc_s  = PC_W'(operand_s);
  assign pc_inc_s  = pc_r + PC_ONE;
  assign in_idx_s  = operand_s[IN_AW-1:0];
  assign out_idx_s = operand_s[OUT_AW-1:0];
  assign in_ok_s   = ({1'b0, operand_s} < IN_LIM);
  assign out_ok_s  = ({1'b0, operand_s} < OUT_LIM);

  // Out-of-range input addresses read as logic 0
  assign core_data = in_ok_s ? in_pins[in_idx_s] : 1'b0;

  assign prog_addr = pc_r;
  assign out_pins  = out_r;
  assign stack_err = err_r;

  mc14500_retstack #(
    .DEPTH(STACK_DEPTH),
    .WIDTH(PC_W)
  ) u_retstack (
    .clk      (clk),
    .rst      (RST),
    .push     (push_s),
    .pop      (pop_s),
    .push_data(pc_inc_s),
    .top      (top_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  // Next-PC selection: RTN over CALL over JMP over sequential fetch
  always_comb begin
    pc_next_s = pc_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    if (run) begin
      if (core_rtn) begin
        if (!empty_s) begin
          pop_s     = 1'b1;
          pc_next_s = top_s;
        end else begin
          err_set_s = 1'b1;
          pc_next_s = pc_inc_s;
        end
      end else if (core_flag_f) begin
        if (!full_s) begin
          push_s    = 1'b1;
          pc_next_s = opr_pc_s;
        end else begin
          err_set_s = 1'b1;
          pc_next_s = pc_inc_s;
        end
      end else if (core_jmp) begin
        pc_next_s = opr_pc_s;
      end else begin
        pc_next_s = pc_inc_s;
      end
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC, output latches and sticky stack error
  always_ff @(posedge clk) begin
    if (RST) begin
      pc_r  <= {PC_W{1'b0}};
      out_r <= {OUT_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      pc_r <= pc_next_s;
      if (err_set_s) begin
        err_r <= 1'b1;
      end
      if (run && core_write && out_ok_s) begin
        out_r[out_idx_s] <= core_dout;
      end
    end
  end

endmodule
